egress_queue: RTL and testbench

EGRESS_QUEUE -- requirements
Module: egress_queue

---
 rtl/switch_pkg.sv | 13 +
 rtl/egress_queue_if.sv | 28 ++
 rtl/egress_fifo.sv | 52 +++++
 rtl/egress_queue.sv | 53 +++++
 tb/tb_egress_queue.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/switch_pkg.sv
// Shared switch-fabric defaults and types for the egress queue slice.
package switch_pkg;
  localparam int WIDTH_DEF = 128;
  localparam int PORTS_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef logic [WIDTH_DEF-1:0]         word_t;
  typedef logic [$clog2(PORTS_DEF)-1:0] port_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/egress_queue_if.sv
// Ingress handshake plus per-port egress bus of the egress queue block.
interface egress_queue_if #(
  parameter int WIDTH = switch_pkg::WIDTH_DEF,
  parameter int PORTS = switch_pkg::PORTS_DEF,
  parameter int DEPTH = switch_pkg::DEPTH_DEF
);
  localparam int PW = $clog2(PORTS);
  localparam int OW = $clog2(DEPTH+1);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [PW-1:0]        in_port;
  logic [PORTS-1:0]     out_valid;
  logic [PORTS-1:0]     out_ready;
  logic [WIDTH-1:0]     out_data  [PORTS];
  logic [OW-1:0]        occupancy [PORTS];
  logic [15:0]          drop_count;

  modport master (
    output in_valid, in_data, in_port, out_ready,
    input  in_ready, out_valid, out_data, occupancy, drop_count
  );
  modport slave (
    input  in_valid, in_data, in_port, out_ready,
    output in_ready, out_valid, out_data, occupancy, drop_count
  );
endinterface

// File: rtl/egress_fifo.sv
// One per-port queue: DEPTH-entry circular buffer, head word zeroed when empty.
module egress_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    occ;
  logic             push_ok, pop_ok;

  assign full      = (occ == OW'(DEPTH));
  assign empty     = (occ == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign occupancy = occ;
  assign data      = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: it is only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: rtl/egress_queue.sv
// Demuxes ingress words into PORTS independent egress FIFOs.
// Define EGRESS_DROP_EN to drop words aimed at a full queue instead of backpressuring.
module egress_queue
  import switch_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PORTS = PORTS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic           clk,
  input logic           reset,
  egress_queue_if.slave bus
);
  localparam int PW = $clog2(PORTS);

  logic [PORTS-1:0] full, empty, push, pop;
  logic             full_sel, accept;

  assign full_sel = full[bus.in_port];
  assign accept   = bus.in_valid && bus.in_ready;

`ifdef EGRESS_DROP_EN
  assign bus.in_ready = !reset;

  // A word accepted for a full queue is the only drop source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  bus.drop_count <= '0;
    else if (accept && full_sel) bus.drop_count <= sat_inc16(bus.drop_count);
  end
`else
  assign bus.in_ready   = !reset && !full_sel;
  assign bus.drop_count = '0;
`endif

  assign bus.out_valid = ~empty;

  for (genvar p = 0; p < PORTS; p++) begin : g_q
    assign push[p] = accept && (bus.in_port == PW'(p)) && !full[p];
    assign pop[p]  = bus.out_ready[p] && !empty[p];

    egress_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[p]),
      .pop       (pop[p]),
      .push_data (bus.in_data),
      .data      (bus.out_data[p]),
      .occupancy (bus.occupancy[p]),
      .full      (full[p]),
      .empty     (empty[p])
    );
  end
endmodule

// File: tb/tb_egress_queue.sv
// Randomized bench for egress_queue against a queue-per-port reference model.
module tb_egress_queue;
  localparam int W  = 128;
  localparam int P  = 16;
  localparam int D  = 4;
  localparam int PW = $clog2(P);
`ifdef EGRESS_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  egress_queue_if #(.WIDTH(W), .PORTS(P), .DEPTH(D)) bus ();
  egress_queue #(.WIDTH(W), .PORTS(P), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one queue per port, plus a drop counter.
  logic [W-1:0] mq [P][$];
  int           mdrop = 0;
  bit           track2 = 1'b0;
  logic [W-1:0] popped2 [$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < P; p++) mq[p].delete();
      mdrop = 0;
    end else begin
      int pre [P];
      bit rdy;
      int ip;
      logic [W-1:0] w;
      for (int p = 0; p < P; p++) pre[p] = mq[p].size();
      ip  = int'(bus.in_port);
      rdy = DROP ? 1'b1 : (pre[ip] < D);
      for (int p = 0; p < P; p++)
        if (pre[p] > 0 && bus.out_ready[p]) begin
          w = mq[p].pop_front();
          if (p == 2 && track2) popped2.push_back(w);
        end
      if (bus.in_valid && rdy) begin
        if (pre[ip] < D) mq[ip].push_back(bus.in_data);
        else if (mdrop < 65535) mdrop++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [P-1:0] ev;
    logic [W-1:0] ad, ed, ao, eo;
    bit exp_rdy;
    ev = '0;
    ad = '0; ed = '0; ao = '0; eo = '0;
    for (int p = P-1; p >= 0; p--) begin
      logic [W-1:0] e;
      ev[p] = (mq[p].size() > 0);
      e = ev[p] ? mq[p][0] : '0;
      if (bus.out_data[p] !== e || p == 0) begin ad = bus.out_data[p]; ed = e; end
      if (bus.occupancy[p] !== 3'(mq[p].size()) || p == 0) begin
        ao = W'(bus.occupancy[p]); eo = W'(mq[p].size());
      end
    end
    exp_rdy = reset ? 1'b0 : (DROP ? 1'b1 : (mq[int'(bus.in_port)].size() < D));
    check("out_valid",  W'(bus.out_valid), W'(ev));
    check("out_data",   ad, ed);
    check("occupancy",  ao, eo);
    check("drop_count", W'(bus.drop_count), W'(mdrop));
    check("in_ready",   W'(bus.in_ready), W'(exp_rdy));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int port, input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_port  = PW'(port);
    bus.in_data  = d;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = '1;
    repeat (D+1) cyc();
    bus.out_ready = '0;
  endtask

  initial begin
    int sent, cycles;
    bus.in_valid  = 1'b0;
    bus.in_port   = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    cyc(); cyc();
    check("rst_ready", W'(bus.in_ready), '0);
    check("rst_valid", W'(bus.out_valid), '0);
    check("rst_drop",  W'(bus.drop_count), '0);
    reset = 1'b0;

    // First edge after reset accepts a push.
    push1(3, 'hA5);
    check("t1_valid", W'(bus.out_valid), W'(16'h0008));
    check("t1_data",  bus.out_data[3], 'hA5);
    check("t1_occ",   W'(bus.occupancy[3]), 1);
    drain();

    for (int i = 1; i <= 4; i++) push1(0, W'(i));
    check("fill0_occ", W'(bus.occupancy[0]), 4);
    bus.out_ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("order0", bus.out_data[0], W'(i));
      cyc();
    end
    bus.out_ready = '0;
    check("empty0_occ", W'(bus.occupancy[0]), 0);

    for (int i = 0; i < 4; i++) push1(5, W'(10 + i));
    bus.in_valid = 1'b1; bus.in_port = PW'(5); bus.in_data = 'd99;
    #1;
    check("full5_ready", W'(bus.in_ready), W'(DROP));
    cyc();
    bus.in_valid = 1'b0;
    check("full5_drop", W'(bus.drop_count), W'(DROP));
    check("full5_occ",  W'(bus.occupancy[5]), 4);
    check("full5_head", bus.out_data[5], 'd10);
    drain();

    push1(7, 'd20); push1(7, 'd21);
    bus.in_valid = 1'b1; bus.in_port = PW'(7); bus.in_data = 'd22;
    bus.out_ready[7] = 1'b1;
    cyc();
    bus.in_valid = 1'b0; bus.out_ready = '0;
    check("pp7_occ",  W'(bus.occupancy[7]), 2);
    check("pp7_head", bus.out_data[7], 'd21);
    drain();

    for (int i = 0; i < 3; i++) push1(9, W'(31 + i));
    reset = 1'b1;
    #1;
    check("rst9_valid", W'(bus.out_valid), '0);
    check("rst9_occ",   W'(bus.occupancy[9]), 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("post9_valid", W'(bus.out_valid), '0);
    push1(9, 'd77);
    check("post9_alone", W'(bus.out_valid), W'(16'h0200));
    check("post9_data",  bus.out_data[9], 'd77);
    check("post9_occ",   W'(bus.occupancy[9]), 1);
    drain();

    // Eight wraps of queue 2 with random pops.
    track2 = 1'b1; sent = 0; cycles = 0;
    while (popped2.size() < 32 && cycles < 1000) begin
      bus.out_ready    = '0;
      bus.out_ready[2] = 1'($urandom_range(0, 1));
      if (sent < 32 && mq[2].size() < D) begin
        bus.in_valid = 1'b1; bus.in_port = PW'(2); bus.in_data = W'(sent); sent++;
      end else bus.in_valid = 1'b0;
      cyc();
      cycles++;
    end
    track2 = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = '0;
    check("wrap2_count", W'(popped2.size()), 32);
    for (int i = 0; i < popped2.size(); i++) check("wrap2_data", popped2[i], W'(i));

    // Random mixed traffic on all ports.
    repeat (400) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_port   = PW'($urandom_range(0, P-1));
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = P'($urandom & $urandom);
      cyc();
    end
    bus.in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
